// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: RV32I/RV64I immediate decoder with PC-relative target, feeding a
// valid/ready output stage that is either a 2-entry skid buffer or a single register.
`default_nettype none

module imm_gen_pipe #(
  parameter int XLEN = 32,
  parameter bit SKID = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [2:0]      in_sel,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_target,
  output logic            out_illegal
);

  localparam logic [1:0] c_EMPTY = 2'd0;
  localparam logic [1:0] c_ONE   = 2'd1;
  localparam logic [1:0] c_FULL  = 2'd2;

  logic [5:0]      w_shamt;
  logic [31:0]     w_imm32;
  logic            w_illegal;
  logic [XLEN-1:0] w_imm;
  logic [XLEN-1:0] w_target;
  logic            w_unused_ok;

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] out_imm_q, out_target_q;
  logic            out_illegal_q;
  logic [XLEN-1:0] skid_imm_q, skid_target_q;
  logic            skid_illegal_q;

  logic            w_accept, w_drain;
  logic            w_load_new, w_load_skid, w_fill_skid;

  // Opcode field never feeds an immediate.
  assign w_unused_ok = &{1'b0, in_inst[6:0]};

  if (XLEN == 64) begin : g_shamt64
    assign w_shamt = in_inst[25:20];
  end else begin : g_shamt32
    assign w_shamt = {1'b0, in_inst[24:20]};
  end

  always_comb begin
    w_imm32   = 32'd0;
    w_illegal = 1'b0;
    case (in_sel)
      3'b000: w_imm32 = {in_inst[31:12], 12'h000};
      3'b001: w_imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
      3'b010: w_imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      3'b011: w_imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                         in_inst[11:8], 1'b0};
      3'b100: w_imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                         in_inst[30:21], 1'b0};
      3'b101: w_imm32 = {26'd0, w_shamt};
      3'b110: w_imm32 = {27'd0, in_inst[19:15]};
      default: w_illegal = 1'b1;
    endcase
  end

  // SHAMT/ZIMM have bit 31 clear, so one sign-extension covers every selector.
  if (XLEN == 64) begin : g_ext64
    assign w_imm = {{32{w_imm32[31]}}, w_imm32};
  end else begin : g_ext32
    assign w_imm = w_imm32;
  end

  assign w_target = in_pc + w_imm;

  assign out_valid   = (state_q != c_EMPTY);
  assign out_imm     = out_imm_q;
  assign out_target  = out_target_q;
  assign out_illegal = out_illegal_q;

  if (SKID) begin : g_skid_ready
    assign in_ready = (state_q != c_FULL);
  end else begin : g_reg_ready
    assign in_ready = ~out_valid | out_ready;
  end

  assign w_accept = in_valid & in_ready & ~flush;
  assign w_drain  = out_valid & out_ready;

  always_comb begin
    state_d     = state_q;
    w_load_new  = 1'b0;
    w_load_skid = 1'b0;
    w_fill_skid = 1'b0;
    if (flush) begin
      state_d = c_EMPTY;
    end else begin
      case (state_q)
        c_EMPTY: begin
          if (w_accept) begin
            state_d    = c_ONE;
            w_load_new = 1'b1;
          end
        end
        c_ONE: begin
          if (w_accept && w_drain) begin
            w_load_new = 1'b1;
          end else if (w_accept) begin
            if (SKID) begin
              state_d     = c_FULL;
              w_fill_skid = 1'b1;
            end
          end else if (w_drain) begin
            state_d = c_EMPTY;
          end
        end
        c_FULL: begin
          if (w_drain) begin
            state_d     = c_ONE;
            w_load_skid = 1'b1;
          end
        end
        default: state_d = c_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= c_EMPTY;
      out_imm_q      <= '0;
      out_target_q   <= '0;
      out_illegal_q  <= 1'b0;
      skid_imm_q     <= '0;
      skid_target_q  <= '0;
      skid_illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (w_load_new) begin
        out_imm_q     <= w_imm;
        out_target_q  <= w_target;
        out_illegal_q <= w_illegal;
      end else if (w_load_skid) begin
        out_imm_q     <= skid_imm_q;
        out_target_q  <= skid_target_q;
        out_illegal_q <= skid_illegal_q;
      end
      if (w_fill_skid) begin
        skid_imm_q     <= w_imm;
        skid_target_q  <= w_target;
        skid_illegal_q <= w_illegal;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
// Directed self-checking bench for imm_gen_pipe (XLEN=32 and XLEN=64 instances).
`default_nettype none

module tb_imm_gen_pipe;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [2:0]  in_sel;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_imm;
  logic [31:0] out_target;
  logic        out_illegal;

  logic        flush64;
  logic        in_valid64;
  logic        in_ready64;
  logic [31:0] in_inst64;
  logic [2:0]  in_sel64;
  logic [63:0] in_pc64;
  logic        out_valid64;
  logic        out_ready64;
  logic [63:0] out_imm64;
  logic [63:0] out_target64;
  logic        out_illegal64;

  int n_checks;
  int n_errors;

  imm_gen_pipe #(.XLEN(32), .SKID(1'b1)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_sel(in_sel), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_imm(out_imm), .out_target(out_target), .out_illegal(out_illegal)
  );

  imm_gen_pipe #(.XLEN(64), .SKID(1'b1)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush64),
    .in_valid(in_valid64), .in_ready(in_ready64),
    .in_inst(in_inst64), .in_sel(in_sel64), .in_pc(in_pc64),
    .out_valid(out_valid64), .out_ready(out_ready64),
    .out_imm(out_imm64), .out_target(out_target64), .out_illegal(out_illegal64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] inst, input logic [2:0] sel, input logic [31:0] pc);
    in_valid = 1'b1;
    in_inst  = inst;
    in_sel   = sel;
    in_pc    = pc;
  endtask

  task automatic single(input string tag, input logic [31:0] inst, input logic [2:0] sel,
                        input logic [31:0] pc, input logic [31:0] e_imm,
                        input logic [31:0] e_tgt, input logic e_ill);
    drive(inst, sel, pc);
    step();
    in_valid = 1'b0;
    check({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
    check({tag, "_imm"}, {32'd0, out_imm}, {32'd0, e_imm});
    check({tag, "_target"}, {32'd0, out_target}, {32'd0, e_tgt});
    check({tag, "_illegal"}, {63'd0, out_illegal}, {63'd0, e_ill});
    step();
  endtask

  task automatic single64(input string tag, input logic [31:0] inst, input logic [2:0] sel,
                          input logic [63:0] e_imm, input logic e_ill);
    in_valid64 = 1'b1;
    in_inst64  = inst;
    in_sel64   = sel;
    step();
    in_valid64 = 1'b0;
    check({tag, "_valid"}, {63'd0, out_valid64}, 64'd1);
    check({tag, "_imm"}, out_imm64, e_imm);
    check({tag, "_target"}, out_target64, e_imm);
    check({tag, "_illegal"}, {63'd0, out_illegal64}, {63'd0, e_ill});
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    rst_n       = 1'b0;
    flush       = 1'b0;
    in_valid    = 1'b0;
    in_inst     = 32'd0;
    in_sel      = 3'd0;
    in_pc       = 32'd0;
    out_ready   = 1'b1;
    flush64     = 1'b0;
    in_valid64  = 1'b0;
    in_inst64   = 32'd0;
    in_sel64    = 3'd0;
    in_pc64     = 64'd0;
    out_ready64 = 1'b1;

    #2;
    check("rst_valid", {63'd0, out_valid}, 64'd0);
    check("rst_ready", {63'd0, in_ready}, 64'd1);
    check("rst_imm", {32'd0, out_imm}, 64'd0);
    check("rst_target", {32'd0, out_target}, 64'd0);
    check("rst_illegal", {63'd0, out_illegal}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    single("I",     32'hFFF00093, 3'b001, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    single("B",     32'hFE000EE3, 3'b011, 32'h0000_0100, 32'hFFFF_FFFC, 32'h0000_00FC, 1'b0);
    single("Jwrap", 32'h0100006F, 3'b100, 32'hFFFF_FFF8, 32'h0000_0010, 32'h0000_0008, 1'b0);
    single("S",     32'hFE112E23, 3'b010, 32'h0000_0000, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0);
    single("U",     32'h12345037, 3'b000, 32'h0000_0010, 32'h1234_5000, 32'h1234_5010, 1'b0);
    single("SH32",  32'h03F00000, 3'b101, 32'h0000_0004, 32'h0000_001F, 32'h0000_0023, 1'b0);
    single("ZIMM",  32'h800F8000, 3'b110, 32'h0000_0000, 32'h0000_001F, 32'h0000_001F, 1'b0);
    single("ILL",   32'hFFFFFFFF, 3'b111, 32'h0000_0040, 32'h0000_0000, 32'h0000_0040, 1'b1);

    // Backpressure: third push is held upstream, then drain in order without bubbles.
    out_ready = 1'b0;
    drive(32'h00100093, 3'b001, 32'd0);
    check("bp_ready1", {63'd0, in_ready}, 64'd1);
    step();
    check("bp_out1", {32'd0, out_imm}, 64'd1);
    drive(32'h00200093, 3'b001, 32'd0);
    check("bp_ready2", {63'd0, in_ready}, 64'd1);
    step();
    check("bp_hold1", {32'd0, out_imm}, 64'd1);
    drive(32'h00300093, 3'b001, 32'd0);
    check("bp_ready3", {63'd0, in_ready}, 64'd0);
    step();
    check("bp_stable", {32'd0, out_imm}, 64'd1);
    check("bp_stall", {63'd0, in_ready}, 64'd0);
    out_ready = 1'b1;
    step();
    check("bp_drain2_v", {63'd0, out_valid}, 64'd1);
    check("bp_drain2", {32'd0, out_imm}, 64'd2);
    check("bp_ready_one", {63'd0, in_ready}, 64'd1);
    step();
    in_valid = 1'b0;
    check("bp_drain3_v", {63'd0, out_valid}, 64'd1);
    check("bp_drain3", {32'd0, out_imm}, 64'd3);
    step();
    check("bp_empty", {63'd0, out_valid}, 64'd0);

    // Flush with buffer full and a valid input on the same cycle.
    out_ready = 1'b0;
    drive(32'h00100093, 3'b001, 32'd0);
    step();
    drive(32'h00200093, 3'b001, 32'd0);
    step();
    check("fl_full", {63'd0, in_ready}, 64'd0);
    drive(32'h00700093, 3'b001, 32'd0);
    flush = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("fl_valid", {63'd0, out_valid}, 64'd0);
    check("fl_ready", {63'd0, in_ready}, 64'd1);
    check("fl_hold_imm", {32'd0, out_imm}, 64'd1);
    step();
    check("fl_dropped", {63'd0, out_valid}, 64'd0);

    // Accept with flush while empty and in_ready=1 must also be dropped.
    drive(32'h00500093, 3'b001, 32'd0);
    flush = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("fl_empty_drop", {63'd0, out_valid}, 64'd0);

    // Asynchronous reset mid-cycle while full.
    drive(32'h00100093, 3'b001, 32'd0);
    step();
    drive(32'h00200093, 3'b001, 32'd0);
    step();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid", {63'd0, out_valid}, 64'd0);
    check("ar_imm", {32'd0, out_imm}, 64'd0);
    check("ar_target", {32'd0, out_target}, 64'd0);
    check("ar_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    step();
    check("ar_after", {63'd0, out_valid}, 64'd0);

    single64("LUI64",  32'h800000B7, 3'b000, 64'hFFFF_FFFF_8000_0000, 1'b0);
    single64("SH64",   32'h03F00000, 3'b101, 64'd63, 1'b0);
    single64("ILL64",  32'hFFFFFFFF, 3'b111, 64'd0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
